// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: pipeline stall/bubble/hold scheduler for load-use, memory wait, MDU wait and debug halt
module pipe_hazard_sched #(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        load_use,
  input  logic        mdu_start,
  input  logic        mdu_done,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  output logic        wpcir,
  output logic        idexe_bubble,
  output logic        pipe_hold,
  output logic [2:0]  state,
  output logic        mdu_err,
  output logic [15:0] stall_cnt
);
  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] LDSTALL = 3'd1;
  localparam logic [2:0] MDUWAIT = 3'd2;
  localparam logic [2:0] MEMWAIT = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;
  localparam int TW = $clog2(MDU_TIMEOUT) < 1 ? 1 : $clog2(MDU_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(MDU_TIMEOUT - 1);
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          w, b, h, eval;
  always_comb begin
    eval    = state_q == RUN || state_q == LDSTALL || (state_q == MEMWAIT && mem_ready);
    w       = 1'b1;
    b       = 1'b0;
    h       = 1'b0;
    state_d = RUN;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (eval) begin
      if (mem_req && !mem_ready) begin
        w       = 1'b0;
        h       = 1'b1;
        state_d = MEMWAIT;
      end else if (load_use && state_q != LDSTALL) begin
        w       = 1'b0;
        b       = 1'b1;
        state_d = LDSTALL;
      end else if (mdu_start) begin
        state_d = MDUWAIT;
        tmo_d   = '0;
      end else if (dbg_halt) begin
        w       = 1'b0;
        h       = 1'b1;
        state_d = HALT;
      end
    end else if (state_q == MEMWAIT) begin
      w       = 1'b0;
      h       = 1'b1;
      state_d = MEMWAIT;
    end else if (state_q == MDUWAIT && !mdu_done) begin
      w = 1'b0;
      h = 1'b1;
      if (tmo_q == LAST) err_d = 1'b1;
      else begin
        state_d = MDUWAIT;
        tmo_d   = tmo_q + 1'b1;
      end
    end else if (state_q == HALT) begin
      w       = dbg_step;
      h       = !dbg_step;
      state_d = dbg_halt ? HALT : RUN;
    end
    cnt_d = (!w && state_q != HALT && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wpcir        = reset ? 1'b0 : w;
  assign idexe_bubble = reset ? 1'b1 : b;
  assign pipe_hold    = reset ? 1'b0 : h;
  assign state        = state_q;
  assign mdu_err      = err_q;
  assign stall_cnt    = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: directed vectors feeding an expected-response queue checked by an independent monitor
module tb_pipe_hazard_sched;
  localparam logic [7:0] I_RST = 8'h80;
  localparam logic [7:0] I_MRQ = 8'h40;
  localparam logic [7:0] I_RDY = 8'h20;
  localparam logic [7:0] I_LU  = 8'h10;
  localparam logic [7:0] I_MS  = 8'h08;
  localparam logic [7:0] I_MD  = 8'h04;
  localparam logic [7:0] I_DH  = 8'h02;
  localparam logic [7:0] I_DS  = 8'h01;
  typedef struct {
    string       nm;
    logic [22:0] v;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0, mem_ready = 1'b0, load_use = 1'b0, mdu_start = 1'b0;
  logic        mdu_done = 1'b0, dbg_halt = 1'b0, dbg_step = 1'b0;
  logic        wpcir, idexe_bubble, pipe_hold, mdu_err;
  logic [2:0]  state;
  logic [15:0] stall_cnt;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  pipe_hazard_sched #(.MDU_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_ready(mem_ready),
    .load_use(load_use), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step), .wpcir(wpcir),
    .idexe_bubble(idexe_bubble), .pipe_hold(pipe_hold), .state(state),
    .mdu_err(mdu_err), .stall_cnt(stall_cnt)
  );
  always #5 clock = ~clock;
  task automatic cyc(input string nm, input logic [7:0] in, input logic [2:0] st,
                     input logic w, input logic b, input logic h, input logic e,
                     input logic [15:0] cnt);
    exp_t x;
    @(posedge clock);
    #1;
    {reset, mem_req, mem_ready, load_use, mdu_start, mdu_done, dbg_halt, dbg_step} = in;
    x.nm = nm;
    x.v  = {st, w, b, h, e, cnt};
    q.push_back(x);
  endtask
  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [22:0] act;
      x   = q.pop_front();
      act = {state, wpcir, idexe_bubble, pipe_hold, mdu_err, stall_cnt};
      n_chk++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d w=%b b=%b h=%b err=%b cnt=%0d, want st=%0d w=%b b=%b h=%b err=%b cnt=%0d",
                 x.nm, act[22:20], act[19], act[18], act[17], act[16], act[15:0],
                 x.v[22:20], x.v[19], x.v[18], x.v[17], x.v[16], x.v[15:0]);
      end
    end
  end
  initial begin
    cyc("reset",        I_RST,                0, 0, 1, 0, 0, 0);
    cyc("idle",         8'h00,                0, 1, 0, 0, 0, 0);
    cyc("lu_bubble",    I_LU,                 0, 0, 1, 0, 0, 0);
    cyc("lu_ldstall",   8'h00,                1, 1, 0, 0, 0, 1);
    cyc("lu_back_run",  8'h00,                0, 1, 0, 0, 0, 1);
    cyc("lu2_bubble",   I_LU,                 0, 0, 1, 0, 0, 1);
    cyc("lu2_ignored",  I_LU,                 1, 1, 0, 0, 0, 2);
    cyc("lu2_run",      8'h00,                0, 1, 0, 0, 0, 2);
    cyc("mem_wait0",    I_MRQ,                0, 0, 0, 1, 0, 2);
    cyc("mem_wait1",    I_MRQ,                3, 0, 0, 1, 0, 3);
    cyc("mem_wait2",    I_MRQ,                3, 0, 0, 1, 0, 4);
    cyc("mem_ready",    I_MRQ | I_RDY,        3, 1, 0, 0, 0, 5);
    cyc("mem_run",      8'h00,                0, 1, 0, 0, 0, 5);
    cyc("mdu_start",    I_MS,                 0, 1, 0, 0, 0, 5);
    cyc("mdu_ign_lu",   I_LU | I_MRQ,         2, 0, 0, 1, 0, 5);
    cyc("mdu_ign_dh",   I_DH,                 2, 0, 0, 1, 0, 6);
    cyc("mdu_wait3",    8'h00,                2, 0, 0, 1, 0, 7);
    cyc("mdu_wait4",    8'h00,                2, 0, 0, 1, 0, 8);
    cyc("mdu_done",     I_MD,                 2, 1, 0, 0, 0, 9);
    cyc("mdu_run",      8'h00,                0, 1, 0, 0, 0, 9);
    cyc("tmo_start",    I_MS,                 0, 1, 0, 0, 0, 9);
    for (int i = 0; i < 7; i++)
      cyc("tmo_wait",   8'h00,                2, 0, 0, 1, 0, 16'(9 + i));
    cyc("tmo_last",     8'h00,                2, 0, 0, 1, 0, 16);
    cyc("tmo_err_run",  8'h00,                0, 1, 0, 0, 1, 17);
    cyc("tmo_err_hold", 8'h00,                0, 1, 0, 0, 1, 17);
    cyc("halt_enter",   I_DH,                 0, 0, 0, 1, 1, 17);
    cyc("halt_hold",    I_DH,                 4, 0, 0, 1, 1, 18);
    cyc("halt_step",    I_DH | I_DS,          4, 1, 0, 0, 1, 18);
    cyc("halt_after",   I_DH,                 4, 0, 0, 1, 1, 18);
    cyc("halt_release", 8'h00,                4, 0, 0, 1, 1, 18);
    cyc("halt_run",     8'h00,                0, 1, 0, 0, 1, 18);
    cyc("step_ignored", I_DS,                 0, 1, 0, 0, 1, 18);
    cyc("halt2_enter",  I_DH,                 0, 0, 0, 1, 1, 18);
    cyc("halt2_hold",   I_DH,                 4, 0, 0, 1, 1, 19);
    cyc("halt2_reset",  I_RST | I_DH,         4, 0, 1, 0, 1, 19);
    cyc("post_reset",   8'h00,                0, 1, 0, 0, 0, 0);
    cyc("mdu2_start",   I_MS,                 0, 1, 0, 0, 0, 0);
    cyc("mdu2_wait",    8'h00,                2, 0, 0, 1, 0, 0);
    cyc("mdu2_reset",   I_RST,                2, 0, 1, 0, 0, 1);
    cyc("mdu2_post",    8'h00,                0, 1, 0, 0, 0, 0);
    cyc("mem2_wait",    I_MRQ,                0, 0, 0, 1, 0, 0);
    cyc("mem2_rdy_lu",  I_MRQ | I_RDY | I_LU, 3, 0, 1, 0, 0, 1);
    cyc("mem2_ldstall", 8'h00,                1, 1, 0, 0, 0, 2);
    cyc("mem2_run",     8'h00,                0, 1, 0, 0, 0, 2);
    cyc("prio_ms_lu",   I_MRQ | I_LU,         0, 0, 0, 1, 0, 2);
    cyc("prio_ready",   I_MRQ | I_RDY,        3, 1, 0, 0, 0, 3);
    cyc("prio_run",     8'h00,                0, 1, 0, 0, 0, 3);
    repeat (3) @(posedge clock);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
